// File: rtl/sdram_fill_pkg.sv
// Shared types for the SDRAM line-fill port: FSM states, burst length and
// the 2-bit word index used by the line buffer pointers.
package sdram_fill_pkg;

  localparam int BURST_LEN = 4;

  typedef logic [1:0] word_idx_t;

  localparam word_idx_t LAST_IDX = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    COLLECT = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4,
    WRITE   = 3'd5
  } fill_state_e;

  function automatic word_idx_t idx_inc(input word_idx_t idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/sdram_fill_port_if.sv
// Cache-side and sequencer-side signals of the fill port, bundled so the
// port sees the slave view and its environment the master view.
interface sdram_fill_port_if #(
  parameter int MEM_AW = 25
);

  logic [31:0]       cache_addr;
  logic              cache_req;
  logic              cache_rw;
  logic [15:0]       cache_wdata;
  logic              cache_fill;
  logic [15:0]       cache_rdata;
  logic              cache_wr_done;

  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic              mem_rdvalid;
  logic [15:0]       mem_rdata;

  modport slave (
    input  cache_addr, cache_req, cache_rw, cache_wdata,
    output cache_fill, cache_rdata, cache_wr_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdvalid, mem_rdata
  );

  modport master (
    output cache_addr, cache_req, cache_rw, cache_wdata,
    input  cache_fill, cache_rdata, cache_wr_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdvalid, mem_rdata
  );

endinterface

// File: rtl/fill_line_buffer.sv
// Four-word line buffer: one write port and one registered read port.
// Pointers are owned by the fill port controller.
module fill_line_buffer
  import sdram_fill_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  word_idx_t   wptr,
  input  logic [15:0] wdata,
  input  word_idx_t   rptr,
  output logic [15:0] rdata
);

  logic [15:0] mem_q [BURST_LEN];
  logic [15:0] mem_d [BURST_LEN];
  logic [15:0] rdata_q;
  logic [15:0] rdata_d;

  // Next buffer contents and read data
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wptr] = wdata;
    end else begin
      mem_d[wptr] = mem_q[wptr];
    end
    rdata_d = mem_q[rptr];
  end

  // Buffer storage and read register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        mem_q[i] <= 16'h0000;
      end
      rdata_q <= 16'h0000;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_fill_port.sv
// Cache line-fill responder: one wrapped 4-word SDRAM burst per read, replayed
// to the cache as a fill strobe plus four back-to-back words. FILL_WRITE_EN
// enables real single-word writes; otherwise writes are acknowledged only.
module sdram_fill_port
  import sdram_fill_pkg::*;
#(
  parameter int MEM_AW = 25
) (
  input logic               clk,
  input logic               reset,
  sdram_fill_port_if.slave  bus
);

  fill_state_e       state_q, state_d;
  word_idx_t         wptr_q, wptr_d;
  word_idx_t         rptr_q, rptr_d;
  logic              cache_fill_q, cache_fill_d;
  logic              cache_wr_done_q, cache_wr_done_d;
  logic              mem_req_q, mem_req_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              buf_we_s;
  logic [15:0]       buf_rdata_s;
  logic              unused_s;
`ifdef FILL_WRITE_EN
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
`endif

  // Next-state, pointer and output decode
  always_comb begin
    state_d         = state_q;
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    cache_fill_d    = 1'b0;
    cache_wr_done_d = 1'b0;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    buf_we_s        = 1'b0;
`ifdef FILL_WRITE_EN
    mem_we_d        = mem_we_q;
    mem_wdata_d     = mem_wdata_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cache_req) begin
          if (bus.cache_rw) begin
            state_d    = ISSUE;
            mem_req_d  = 1'b1;
            mem_addr_d = bus.cache_addr[MEM_AW:1];
`ifdef FILL_WRITE_EN
            mem_we_d   = 1'b0;
`endif
          end else begin
            state_d     = WRITE;
`ifdef FILL_WRITE_EN
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.cache_addr[MEM_AW:1];
            mem_wdata_d = bus.cache_wdata;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        // Data may arrive in the same cycle as the acceptance.
        if (bus.mem_rdvalid) begin
          buf_we_s = 1'b1;
          wptr_d   = idx_inc(wptr_q);
        end else begin
          wptr_d = wptr_q;
        end
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = COLLECT;
        end else begin
          state_d = ISSUE;
        end
      end

      COLLECT: begin
        if (bus.mem_rdvalid) begin
          buf_we_s = 1'b1;
          wptr_d   = idx_inc(wptr_q);
          if (wptr_q == LAST_IDX) begin
            state_d      = STREAM;
            cache_fill_d = 1'b1;
            rptr_d       = idx_inc(rptr_q);
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end

      STREAM: begin
        // rptr runs one word ahead of the data register; wrap to 0 marks the last word.
        if (rptr_q == 2'd0) begin
          state_d = DRAIN;
        end else begin
          rptr_d = idx_inc(rptr_q);
        end
      end

      DRAIN: begin
        if (!bus.cache_req) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end

      WRITE: begin
`ifdef FILL_WRITE_EN
        if (bus.mem_ack) begin
          mem_req_d       = 1'b0;
          mem_we_d        = 1'b0;
          cache_wr_done_d = 1'b1;
          state_d         = DRAIN;
        end else begin
          state_d = WRITE;
        end
`else
        cache_wr_done_d = 1'b1;
        state_d         = DRAIN;
`endif
      end

      default: begin
        state_d   = IDLE;
        wptr_d    = 2'd0;
        rptr_d    = 2'd0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      wptr_q          <= 2'd0;
      rptr_q          <= 2'd0;
      cache_fill_q    <= 1'b0;
      cache_wr_done_q <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
`ifdef FILL_WRITE_EN
      mem_we_q        <= 1'b0;
      mem_wdata_q     <= 16'h0000;
`endif
    end else begin
      state_q         <= state_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      cache_fill_q    <= cache_fill_d;
      cache_wr_done_q <= cache_wr_done_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
`ifdef FILL_WRITE_EN
      mem_we_q        <= mem_we_d;
      mem_wdata_q     <= mem_wdata_d;
`endif
    end
  end

  fill_line_buffer u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we_s),
    .wptr  (wptr_q),
    .wdata (bus.mem_rdata),
    .rptr  (rptr_q),
    .rdata (buf_rdata_s)
  );

  assign bus.cache_fill    = cache_fill_q;
  assign bus.cache_rdata   = buf_rdata_s;
  assign bus.cache_wr_done = cache_wr_done_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_addr      = mem_addr_q;
`ifdef FILL_WRITE_EN
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_wdata     = mem_wdata_q;
`else
  assign bus.mem_we        = 1'b0;
  assign bus.mem_wdata     = 16'h0000;
`endif

  assign unused_s = ^{bus.cache_addr[31:MEM_AW+1], bus.cache_addr[0], bus.cache_wdata};

endmodule

// File: tb/tb_sdram_fill_port.sv
// Directed bench for sdram_fill_port: read fills (contiguous, gapped,
// ack-coincident), held request, write, and reset in the middle of a burst.
module tb_sdram_fill_port;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sdram_fill_port_if #(.MEM_AW(25)) bus ();

  sdram_fill_port #(.MEM_AW(25)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed four rdvalid words with 'gap' idle cycles between them, then check the replay.
  task automatic burst(input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3,
                       input int gap, input bit ack_first, input bit drop_req);
    logic [15:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rdvalid = 1'b1;
      bus.mem_rdata   = w[i];
      bus.mem_ack     = (ack_first && i == 0) ? 1'b1 : 1'b0;
      step();
      bus.mem_rdvalid = 1'b0;
      bus.mem_ack     = 1'b0;
      if (i < 3) begin
        chk("fill_early", {31'd0, bus.cache_fill}, 32'd0);
        for (int g = 0; g < gap; g++) begin
          step();
          chk("fill_gap", {31'd0, bus.cache_fill}, 32'd0);
        end
      end
    end
    chk("fill_strobe", {31'd0, bus.cache_fill}, 32'd1);
    chk("word0", {16'd0, bus.cache_rdata}, {16'd0, w[0]});
    if (drop_req) bus.cache_req = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("fill_low", {31'd0, bus.cache_fill}, 32'd0);
      chk("word_n", {16'd0, bus.cache_rdata}, {16'd0, w[k]});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.cache_addr  = 32'h0000_0000;
    bus.cache_req   = 1'b0;
    bus.cache_rw    = 1'b0;
    bus.cache_wdata = 16'h0000;
    bus.mem_ack     = 1'b0;
    bus.mem_rdvalid = 1'b0;
    bus.mem_rdata   = 16'h0000;

    // Reset state
    step();
    step();
    chk("rst_fill", {31'd0, bus.cache_fill}, 32'd0);
    chk("rst_rdata", {16'd0, bus.cache_rdata}, 32'd0);
    chk("rst_wr_done", {31'd0, bus.cache_wr_done}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {7'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    reset = 1'b0;
    step();

    // Contiguous read, ack two cycles after mem_req
    bus.cache_addr = 32'h0000_1234;
    bus.cache_rw   = 1'b1;
    bus.cache_req  = 1'b1;
    step();
    chk("t1_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("t1_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("t1_mem_addr", {7'd0, bus.mem_addr}, 32'h091A);
    step();
    chk("t1_req_hold1", {31'd0, bus.mem_req}, 32'd1);
    step();
    chk("t1_req_hold2", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t1_req_drop", {31'd0, bus.mem_req}, 32'd0);
    burst(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 0, 1'b0, 1'b1);
    repeat (2) step();

    // Gapped return: three idle cycles between words
    bus.cache_addr = 32'h0000_2006;
    bus.cache_req  = 1'b1;
    step();
    chk("t2_mem_addr", {7'd0, bus.mem_addr}, 32'h1003);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t2_req_drop", {31'd0, bus.mem_req}, 32'd0);
    burst(16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3, 3, 1'b0, 1'b1);
    repeat (2) step();

    // Stray rdvalid while idle must be ignored
    bus.mem_rdvalid = 1'b1;
    bus.mem_rdata   = 16'hDEAD;
    step();
    bus.mem_rdvalid = 1'b0;
    step();

    // Ack coincident with first data word
    bus.cache_addr = 32'h0000_0100;
    bus.cache_req  = 1'b1;
    step();
    chk("t3_mem_addr", {7'd0, bus.mem_addr}, 32'h0080);
    burst(16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3, 0, 1'b1, 1'b1);
    repeat (2) step();

    // Single-word write of 0xBEEF at byte 0x10
    bus.cache_addr  = 32'h0000_0010;
    bus.cache_wdata = 16'hBEEF;
    bus.cache_rw    = 1'b0;
    bus.cache_req   = 1'b1;
    step();
`ifdef FILL_WRITE_EN
    chk("wr_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("wr_mem_we", {31'd0, bus.mem_we}, 32'd1);
    chk("wr_mem_addr", {7'd0, bus.mem_addr}, 32'h0008);
    chk("wr_mem_wdata", {16'd0, bus.mem_wdata}, 32'h0000BEEF);
    chk("wr_done_early", {31'd0, bus.cache_wr_done}, 32'd0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("wr_req_drop", {31'd0, bus.mem_req}, 32'd0);
    chk("wr_done", {31'd0, bus.cache_wr_done}, 32'd1);
`else
    chk("wr_mem_req0", {31'd0, bus.mem_req}, 32'd0);
    chk("wr_done_early", {31'd0, bus.cache_wr_done}, 32'd0);
    step();
    chk("wr_done", {31'd0, bus.cache_wr_done}, 32'd1);
    chk("wr_mem_req1", {31'd0, bus.mem_req}, 32'd0);
    chk("wr_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("wr_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
`endif
    bus.cache_req = 1'b0;
    step();
    chk("wr_done_pulse", {31'd0, bus.cache_wr_done}, 32'd0);
    step();

    // Held request: no new mem_req until cache_req has been low
    bus.cache_addr = 32'h0000_0040;
    bus.cache_rw   = 1'b1;
    bus.cache_req  = 1'b1;
    step();
    chk("t4_mem_addr", {7'd0, bus.mem_addr}, 32'h0020);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    burst(16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_no_rereq", {31'd0, bus.mem_req}, 32'd0);
    end
    bus.cache_req  = 1'b0;
    bus.cache_addr = 32'h0000_0A0C;
    step();
    chk("t4_req_low", {31'd0, bus.mem_req}, 32'd0);
    bus.cache_req = 1'b1;
    step();
    chk("t4_rereq", {31'd0, bus.mem_req}, 32'd1);
    chk("t4_rereq_addr", {7'd0, bus.mem_addr}, 32'h0506);

    // Reset after two of four words
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    bus.mem_rdvalid = 1'b1;
    bus.mem_rdata   = 16'h00E0;
    step();
    bus.mem_rdata   = 16'h00E1;
    step();
    bus.mem_rdvalid = 1'b0;
    bus.cache_req   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_fill", {31'd0, bus.cache_fill}, 32'd0);
    chk("mid_rst_rdata", {16'd0, bus.cache_rdata}, 32'd0);
    chk("mid_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mid_rst_mem_addr", {7'd0, bus.mem_addr}, 32'd0);
    chk("mid_rst_wr_done", {31'd0, bus.cache_wr_done}, 32'd0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // New read after reset returns only the new burst
    bus.cache_addr = 32'h0000_0006;
    bus.cache_rw   = 1'b1;
    bus.cache_req  = 1'b1;
    step();
    chk("t6_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("t6_mem_addr", {7'd0, bus.mem_addr}, 32'h0003);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    burst(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3, 0, 1'b0, 1'b1);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_fill_port.md
# sdram_fill_port

SDRAM-side responder for the two-way CPU cache's line-fill interface. Accepts a cache read request, issues one 4-word wrapped burst to the SDRAM sequencer, and buffers the returned words. It then replays them to the cache as one `cache_fill` strobe plus four back-to-back data words, critical word first. It sits between the cache and the SDRAM sequencer slot arbiter.

## Interface
- `MEM_AW`, 25: memory word-address width (64 MB of 16-bit words).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cache_addr`  in  32  byte address; [25:3] line, [2:1] critical word.
- `cache_req`  in  1  level request from cache; held until fill strobe seen.
- `cache_rw`  in  1  1 = line read, 0 = single-word write.
- `cache_wdata`  in  16  write data (used only with `FILL_WRITE_EN`).
- `cache_fill`  out  1  one-cycle strobe marking word 0 on `cache_rdata`.
- `cache_rdata`  out  16  fill data; words 1..3 follow on the next three cycles.
- `cache_wr_done`  out  1  one-cycle write completion pulse.
- `mem_req`  out  1  request to sequencer; held until `mem_ack`.
- `mem_we`  out  1  1 = write access.
- `mem_addr`  out  MEM_AW  word address.
- `mem_wdata`  out  16  write data.
- `mem_ack`  in  1  one-cycle acceptance of the current request.
- `mem_rdvalid`  in  1  qualifies `mem_rdata`, one word per pulse, wrap order, gaps allowed.
- `mem_rdata`  in  16  burst read data.

## Operation
States:
- IDLE
  - `cache_req`=1, `cache_rw`=1 → ISSUE; latch `mem_addr` = {`cache_addr[25:3]`, `cache_addr[2:1]`}; `mem_req`=1, `mem_we`=0.
  - `cache_req`=1, `cache_rw`=0 → WRITE.
- ISSUE
  - Hold `mem_req` until `mem_ack`, then drop it → COLLECT.
  - A `mem_rdvalid` coincident with `mem_ack` is counted.
- COLLECT
  - Each `mem_rdvalid` writes buffer[wptr] and increments 2-bit `wptr`.
  - After the 4th word → STREAM.
- STREAM
  - Cycle 0: `cache_fill`=1, `cache_rdata`=buf[0].
  - Cycles 1..3: buf[1..3], `cache_fill`=0.
  - After cycle 3 → DRAIN.
- DRAIN: wait until `cache_req`=0, then → IDLE. This blocks re-accepting a stale level request.
- WRITE: see Configuration.

Data rules:
- Words stream in arrival order. The sequencer's wrap order starting at the critical index equals the cache's expected order.
- `mem_rdvalid` outside ISSUE/COLLECT is ignored.
- Pulses beyond the 4th in COLLECT cannot occur, because the state leaves on the 4th.
- `cache_rdata` is don't-care outside STREAM and is driven from the buffer read pointer.

## Timing
- All outputs are registered. Reset values: `cache_fill`=0, `cache_rdata`=0, `cache_wr_done`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. State resets to IDLE with both pointers at 0.
- Request latency: `cache_req` sampled at edge N → `mem_req` high after edge N (visible in cycle N+1).
- Fill latency: 4th `mem_rdvalid` at edge M → `cache_fill` in cycle M+1 → words in cycles M+1..M+4.
  - DRAIN is entered at M+5 and IDLE is reached earliest at M+6.
- `cache_fill` is never asserted without all four words buffered, so the cache always sees four consecutive words.
- Reset mid-burst:
  - `mem_req` drops immediately (asynchronous) and partial buffer contents are discarded.
  - The sequencer is responsible for abandoning the burst.

## Configuration
- `FILL_WRITE_EN` defined:
  - WRITE drives `mem_req`=1, `mem_we`=1, `mem_addr`=`cache_addr[25:1]`, `mem_wdata`=`cache_wdata`.
  - On `mem_ack`, drop `mem_req`, pulse `cache_wr_done` next cycle → DRAIN.
- Not defined:
  - WRITE pulses `cache_wr_done` one cycle after entry with no memory access → DRAIN.
  - `mem_we` and `mem_wdata` are constant 0.

## Structure
- Shared package `sdram_fill_pkg`:
  - state enum: IDLE, ISSUE, COLLECT, STREAM, DRAIN, WRITE;
  - `BURST_LEN`=4;
  - 2-bit word-index type.
- One sub-module `fill_line_buffer`: 4×16 register file with write port (`we`, `wptr`) and registered read port (`rptr`). Contains no control logic.

## Test plan
- **Read, contiguous return:** read at `cache_addr`=0x0000_1234, `mem_ack` 2 cycles after `mem_req`, rdvalid words 0xA0,0xA1,0xA2,0xA3 back-to-back → `mem_addr`=0x091A; `cache_fill` one cycle later with 0xA0, then 0xA1..0xA3 on consecutive cycles.
- **Gapped return:** rdvalid with 3 idle cycles between each word → `cache_fill` only one cycle after the 4th word; no gaps in cache stream.
- **Ack and data coincide:** `mem_ack` and first `mem_rdvalid` in the same cycle → word counted; stream order correct.
- **Held request:** `cache_req` held high through the fill and for 5 cycles after → no second `mem_req` until `cache_req` has been low one cycle.
- **Write with and without macro:** write 0xBEEF at 0x0000_0010 → `FILL_WRITE_EN`: `mem_we`=1, `mem_addr`=0x8, `cache_wr_done` after ack; without: `cache_wr_done` one cycle after entry, `mem_req` stays 0.
- **Reset after 2 of 4 words:** → all outputs 0 immediately; next read returns only the new burst's data.
